oam_dma_bus_arbiter: RTL and testbench
======================================

Name: oam_dma_bus_arbiter

Overview:
Owns the single 6502 memory bus and shares it between the CPU core (instruction fetcher plus execute unit) and the OAM DMA engine. A CPU write to the DMA trigger register stalls the CPU. The block then copies one 256-byte page, one byte at a time, into the PPU OAM data port. It then hands the bus back to the CPU. The bus mux and the DMA sequencing FSM live here; the CPU sees only a stall and the read data.

Parameters:
ADDR_WIDTH, 16, memory address width
DATA_WIDTH, 8, memory data width
DMA_REG_ADDR, 16'h4014, CPU write here triggers DMA; wdata is the source page
OAM_DATA_ADDR, 16'h2004, DMA write destination

Ports:
clk  in  1  clock
reset_n  in  1  reset, synchronous, active-low
cpu_addr  in  ADDR_WIDTH  CPU bus address
cpu_wdata  in  DATA_WIDTH  CPU write data
cpu_we  in  1  CPU write strobe
cpu_rdata  out  DATA_WIDTH  read data to CPU (always mem_rdata)
cpu_stall  out  1  CPU must hold state and issue no new bus cycle
mem_addr  out  ADDR_WIDTH  bus address to memory map
mem_wdata  out  DATA_WIDTH  bus write data
mem_we  out  1  bus write strobe
mem_rdata  in  DATA_WIDTH  combinational read data from memory map
dma_active  out  1  high in every non-IDLE state

Behaviour:
- Reset: state=IDLE, cpu_stall=0, dma_active=0, page=0, idx=0, latch=0, cycle_odd=0.
- cycle_odd toggles every clk after reset. cycle_odd=0 is a get (read) cycle; cycle_odd=1 is a put (write) cycle.
- States: IDLE, HALT, ALIGN, READ, WRITE. All are registered, and outputs decode from the current state.
- IDLE:
  - mem_* = cpu_*, passed through combinationally.
  - On cpu_we && cpu_addr==DMA_REG_ADDR: page<=cpu_wdata, idx<=0, next=HALT. The trigger write still reaches the bus.
- HALT (exactly 1 cycle):
  - cpu_stall=1; mem_addr=cpu_addr; mem_we forced 0.
  - next=READ if cycle_odd==1, else ALIGN.
- ALIGN (1 cycle): dummy cycle. mem_addr=cpu_addr, mem_we=0, next=READ.
- READ:
  - Only ever entered on a cycle with cycle_odd==0.
  - Drives mem_addr={page,idx}, mem_we=0; latch<=mem_rdata; next=WRITE.
- WRITE:
  - Drives mem_addr=OAM_DATA_ADDR, mem_wdata=latch, mem_we=1.
  - If idx==8'hFF: next=IDLE. Otherwise idx<=idx+1 and next=READ.
  - idx is 8 bits; the page never crosses (no carry into page).
- cpu_stall=1 and dma_active=1 in HALT, ALIGN, READ and WRITE. Both are 0 in the first IDLE cycle after the final WRITE.
- Total stall: 513 cycles if the trigger write lands on cycle_odd=0; 514 cycles if it lands on cycle_odd=1.
- A DMA_REG_ADDR write while not IDLE is impossible, because the CPU is stalled. If it arrives anyway it is ignored (no re-trigger, page unchanged).
- Reset mid-DMA aborts immediately to reset values; no further OAM writes occur.
- cpu_rdata=mem_rdata in all states. The CPU must ignore it while stalled.

Optional Feature:
OAM_DMA_ALIGN_EN
- Defined: ALIGN state is present; stall is 513 or 514 cycles by parity, as above.
- Undefined: ALIGN is removed and HALT always goes to READ. The cycle_odd check is dropped and stall is always 513 cycles. The READ-on-get rule is not enforced.

Decomposition:
- Shared package: state enum (IDLE/HALT/ALIGN/READ/WRITE), DMA_REG_ADDR, OAM_DATA_ADDR, DMA_LEN=256, ADDR_WIDTH/DATA_WIDTH defaults.
- One sub-module, oam_dma_fsm: holds state, idx, page, latch, cycle_odd and the DMA-side bus drive.
- Top level: the CPU/DMA bus mux and the stall output.

Test Plan:
- Trigger on even cycle: CPU writes 8'h02 to 16'h4014 with cycle_odd=0; page 16'h0200..02FF preloaded with byte=index -> cpu_stall high exactly 513 cycles. 256 writes to 16'h2004 carry data 00..FF in order, each READ addr 16'h0200+n.
- Trigger on odd cycle: same write with cycle_odd=1 -> one ALIGN cycle, stall 514 cycles. Every READ cycle has cycle_odd=0. Data sequence is identical.
- Passthrough: IDLE with CPU write 8'h55 to 16'h0010, then a read of 16'h0010 -> mem_* mirror cpu_*, cpu_rdata=8'h55, cpu_stall stays 0.
- Reset mid-DMA: assert reset_n=0 after the 100th OAM write -> next cycle state IDLE, stall 0, mem_we 0. No further writes to 16'h2004.
- Page boundary: trigger with page 8'hFF -> last read addr 16'hFFFF, then IDLE. No access to 16'h0000.
- Macro off (OAM_DMA_ALIGN_EN undefined): odd-cycle trigger -> stall 513 cycles, no ALIGN state visited.

Source files
------------

// File: rtl/oam_dma_bus_arbiter_pkg.sv
// Shared types and constants for the OAM DMA bus arbiter.
// State encoding, bus widths, register addresses, page length.
package oam_dma_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_ALIGN,
    ST_READ,
    ST_WRITE
  } dma_state_e;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 8;
  localparam int DMA_LEN = 256;

  localparam logic [15:0] DMA_REG_A  = 16'h4014;
  localparam logic [15:0] OAM_DATA_A = 16'h2004;

  localparam logic [7:0] IDX_LAST = 8'(DMA_LEN - 1);

endpackage

// File: rtl/oam_dma_fsm.sv
// OAM DMA sequencer: state, page, idx, latch, cycle parity, DMA bus drive.
// Ports: clk, reset_n, cpu_* (trigger snoop), mem_rdata, dma_* bus drive.
// Macro OAM_DMA_ALIGN_EN: insert ALIGN so READ lands on get (even) cycles.
module oam_dma_fsm
  import oam_dma_bus_arbiter_pkg::*;
#(
  parameter int              ADDR_WIDTH    = ADDR_W,
  parameter int              DATA_WIDTH    = DATA_W,
  parameter logic [ADDR_WIDTH-1:0] DMA_REG_ADDR  = DMA_REG_A,
  parameter logic [ADDR_WIDTH-1:0] OAM_DATA_ADDR = OAM_DATA_A
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic                  cpu_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  dma_active,
  output logic [ADDR_WIDTH-1:0] dma_addr,
  output logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_we
);

`ifdef OAM_DMA_ALIGN_EN
  localparam logic ALIGN_EN = 1'b1;
`else
  localparam logic ALIGN_EN = 1'b0;
`endif

  dma_state_e            state, state_nx;
  logic [DATA_WIDTH-1:0] page, page_nx;
  logic [7:0]            idx, idx_nx;
  logic [DATA_WIDTH-1:0] latch, latch_nx;
  logic                  cycle_odd;
  logic                  trig;
  logic                  need_align;

  assign trig = cpu_we && (cpu_addr == DMA_REG_ADDR);

  // HALT on a get cycle would put READ on a put cycle.
  assign need_align = ALIGN_EN && !cycle_odd;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      page      <= '0;
      idx       <= '0;
      latch     <= '0;
      cycle_odd <= 1'b0;
    end else begin
      state     <= state_nx;
      page      <= page_nx;
      idx       <= idx_nx;
      latch     <= latch_nx;
      cycle_odd <= ~cycle_odd;
    end
  end

  always_comb begin
    state_nx  = state;
    page_nx   = page;
    idx_nx    = idx;
    latch_nx  = latch;
    dma_addr  = cpu_addr;
    dma_wdata = latch;
    dma_we    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (trig) begin
          page_nx  = cpu_wdata;
          idx_nx   = '0;
          state_nx = ST_HALT;
        end
      end
      ST_HALT: begin
        state_nx = need_align ? ST_ALIGN : ST_READ;
      end
      ST_ALIGN: begin
        state_nx = ST_READ;
      end
      ST_READ: begin
        dma_addr = ADDR_WIDTH'({page, idx});
        latch_nx = mem_rdata;
        state_nx = ST_WRITE;
      end
      ST_WRITE: begin
        dma_addr = OAM_DATA_ADDR;
        dma_we   = 1'b1;
        if (idx == IDX_LAST) begin
          state_nx = ST_IDLE;
        end else begin
          idx_nx   = idx + 8'd1;
          state_nx = ST_READ;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign dma_active = (state != ST_IDLE);

endmodule

// File: rtl/oam_dma_bus_arbiter.sv
// Shares the 6502 bus between the CPU and the OAM DMA engine.
// Ports: clk, reset_n, cpu_* in, cpu_rdata/cpu_stall out, mem_* bus, dma_active.
// Macro OAM_DMA_ALIGN_EN: see oam_dma_fsm (parity alignment cycle).
module oam_dma_bus_arbiter
  import oam_dma_bus_arbiter_pkg::*;
#(
  parameter int              ADDR_WIDTH    = ADDR_W,
  parameter int              DATA_WIDTH    = DATA_W,
  parameter logic [ADDR_WIDTH-1:0] DMA_REG_ADDR  = DMA_REG_A,
  parameter logic [ADDR_WIDTH-1:0] OAM_DATA_ADDR = OAM_DATA_A
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic                  cpu_we,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  dma_active
);

  logic [ADDR_WIDTH-1:0] dma_addr;
  logic [DATA_WIDTH-1:0] dma_wdata;
  logic                  dma_we;

  oam_dma_fsm #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .DMA_REG_ADDR  (DMA_REG_ADDR),
    .OAM_DATA_ADDR (OAM_DATA_ADDR)
  ) u_fsm (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_we     (cpu_we),
    .mem_rdata  (mem_rdata),
    .dma_active (dma_active),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_we     (dma_we)
  );

  // Trigger write passes through in IDLE; DMA owns the bus otherwise.
  assign mem_addr  = dma_active ? dma_addr  : cpu_addr;
  assign mem_wdata = dma_active ? dma_wdata : cpu_wdata;
  assign mem_we    = dma_active ? dma_we    : cpu_we;

  assign cpu_stall = dma_active;
  assign cpu_rdata = mem_rdata;

endmodule

// File: tb/tb_oam_dma_bus_arbiter.sv
// Scoreboard bench for oam_dma_bus_arbiter.
// Stimulus pushes expected OAM writes/stall lengths; a monitor pops them.
module tb_oam_dma_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_rdata;
  logic        cpu_stall;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic        dma_active;

  oam_dma_bus_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_we     (cpu_we),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .dma_active (dma_active)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] raddr;
    logic [7:0]  data;
  } oam_exp_t;

  oam_exp_t    oam_q[$];
  int          stall_q[$];
  int          checks = 0;
  int          failures = 0;
  int          oam_cnt = 0;
  int          zero_hits = 0;
  int          stall_cnt = 0;
  logic        tb_odd = 1'b0;
  logic [15:0] prev_addr = '0;
  logic        prev_odd = 1'b0;
  logic [7:0]  ram [0:255];

`ifdef OAM_DMA_ALIGN_EN
  localparam int ODD_STALL = 514;
`else
  localparam int ODD_STALL = 513;
`endif

  // Memory map model: page 00 is RAM, page FF holds idx^A5,
  // every other page returns its low address byte.
  function automatic logic [7:0] map_byte(logic [15:0] a);
    if (a[15:8] == 8'hFF) return a[7:0] ^ 8'hA5;
    return a[7:0];
  endfunction

  always_comb begin
    if (mem_addr[15:8] == 8'h00) mem_rdata = ram[mem_addr[7:0]];
    else mem_rdata = map_byte(mem_addr);
  end

  always @(posedge clk) begin
    if (mem_we && mem_addr[15:8] == 8'h00)
      ram[mem_addr[7:0]] <= mem_wdata;
  end

  always @(posedge clk) tb_odd <= !reset_n ? 1'b0 : ~tb_odd;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    oam_exp_t e;
    if (mem_we && mem_addr == 16'h2004) begin
      oam_cnt++;
      if (oam_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_oam_write actual=%0h required=none",
                 mem_wdata);
      end else begin
        e = oam_q.pop_front();
        check("oam_data", 32'(mem_wdata), 32'(e.data));
        check("read_addr", 32'(prev_addr), 32'(e.raddr));
`ifdef OAM_DMA_ALIGN_EN
        check("read_on_get", 32'(prev_odd), 32'd0);
`endif
      end
    end
    if (dma_active && mem_addr == 16'h0000) zero_hits++;
    if (cpu_stall) begin
      stall_cnt++;
    end else if (stall_cnt > 0) begin
      if (stall_q.size() > 0)
        check("stall_len", 32'(stall_cnt), 32'(stall_q.pop_front()));
      stall_cnt = 0;
    end
    prev_addr = mem_addr;
    prev_odd  = tb_odd;
  end

  task automatic trigger(logic [7:0] page, logic odd, int exp_stall);
    oam_exp_t e;
    @(negedge clk);
    if (tb_odd != odd) @(negedge clk);
    cpu_addr  = 16'h4014;
    cpu_wdata = page;
    cpu_we    = 1'b1;
    for (int i = 0; i < 256; i++) begin
      e.raddr = {page, 8'(i)};
      e.data  = map_byte(e.raddr);
      oam_q.push_back(e);
    end
    if (exp_stall > 0) stall_q.push_back(exp_stall);
    #1;
    check("trig_on_bus_we", 32'(mem_we), 32'd1);
    check("trig_on_bus_addr", 32'(mem_addr), 32'h4014);
    check("trig_stall_low", 32'(cpu_stall), 32'd0);
    @(negedge clk);
    cpu_we = 1'b0;
  endtask

  task automatic wait_done(string name);
    int n = 0;
    while (cpu_stall && n < 700) begin
      @(negedge clk);
      n++;
    end
    if (n >= 700) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=%0d required=<700", name, n);
    end
    @(negedge clk);
    check({name, "_oam_left"}, 32'(oam_q.size()), 32'd0);
    check({name, "_stall_seen"}, 32'(stall_q.size()), 32'd0);
    check({name, "_idle"}, 32'(dma_active), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_active", 32'(dma_active), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);

    // CPU passthrough in IDLE
    @(negedge clk);
    cpu_addr  = 16'h0010;
    cpu_wdata = 8'h55;
    cpu_we    = 1'b1;
    #1;
    check("pt_addr", 32'(mem_addr), 32'h0010);
    check("pt_wdata", 32'(mem_wdata), 32'h55);
    check("pt_we", 32'(mem_we), 32'd1);
    check("pt_stall", 32'(cpu_stall), 32'd0);
    @(negedge clk);
    cpu_we = 1'b0;
    #1;
    check("pt_rdata", 32'(cpu_rdata), 32'h55);
    check("pt_we_rd", 32'(mem_we), 32'd0);
    check("pt_stall_rd", 32'(cpu_stall), 32'd0);

    trigger(8'h02, 1'b0, 513);
    wait_done("even");

    trigger(8'h02, 1'b1, ODD_STALL);
    wait_done("odd");

    zero_hits = 0;
    trigger(8'hFF, 1'b0, 513);
    wait_done("page_ff");
    check("no_zero_access", 32'(zero_hits), 32'd0);

    // Reset in the middle of a transfer
    base = oam_cnt;
    trigger(8'h03, 1'b0, 0);
    n = 0;
    while (oam_cnt < base + 100 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("mid_reached_100", 32'(oam_cnt - base), 32'd100);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_stall", 32'(cpu_stall), 32'd0);
    check("mid_rst_active", 32'(dma_active), 32'd0);
    check("mid_rst_we", 32'(mem_we), 32'd0);
    oam_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    cpu_addr = 16'h0100;
    repeat (600) @(negedge clk);
    check("no_oam_after_rst", 32'(oam_cnt - base), 32'd100);
    check("post_rst_idle", 32'(cpu_stall), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
